// File: rtl/cache_probe_tracer_pkg.sv
// ----------------------------------------------------------------------------
// cache_probe_pkg
// Shared definitions for the cache probe tracer:
//   - controller FSM state codes, matching the cache controller encoding
//   - tracer state enum (IDLE / RUN / POST / DONE)
//   - capture mode codes
//   - trace entry layout helper and event-counter slot indices
// No ports (package).
// ----------------------------------------------------------------------------
package cache_probe_pkg;

    // Cache controller FSM encoding. The tracer only cares about IDLE (reset
    // value of the previous-state register) and the hit / allocate states.
    typedef enum logic [3:0] {
        CS_IDLE     = 4'd0,
        CS_LOOKUP   = 4'd1,
        CS_RD_HIT   = 4'd2,
        CS_WR_HIT   = 4'd3,
        CS_RD_ALLOC = 4'd4,
        CS_WR_ALLOC = 4'd5,
        CS_EVICT    = 4'd6,
        CS_REFILL   = 4'd7
    } ctrl_state_e;

    typedef enum logic [1:0] {
        TR_IDLE = 2'd0,
        TR_RUN  = 2'd1,
        TR_POST = 2'd2,
        TR_DONE = 2'd3
    } tr_state_e;

    // Mode 3 is reserved and behaves exactly like WRAP.
    localparam logic [1:0] MODE_WRAP      = 2'd0;
    localparam logic [1:0] MODE_STOP_FULL = 2'd1;
    localparam logic [1:0] MODE_TRIGGER   = 2'd2;
    localparam logic [1:0] MODE_RSVD      = 2'd3;

    // Event counter slots.
    localparam int NUM_CNT   = 3;
    localparam int CNT_HIT   = 0;
    localparam int CNT_MISS  = 1;
    localparam int CNT_EVICT = 2;

    // Trace entry layout, MSB first: {ts, state, way_idx, hit, addr}.
    function automatic int entry_width(input int ts_w, input int state_w,
                                       input int way_w, input int addr_w);
        return ts_w + state_w + way_w + 1 + addr_w;
    endfunction

endpackage

// File: rtl/cache_probe_tracer_trace_ram.sv
// ----------------------------------------------------------------------------
// trace_ram
// DEPTH x WIDTH simple dual-port memory: one synchronous write port, one
// registered read port. A read and a write to the same address in the same
// cycle return the previous contents (read-before-write).
// Ports:
//   clk            clock, rising edge
//   we/waddr/wdata write port
//   re/raddr       read request; rdata valid after the next edge
//   rdata          registered read data (holds when re=0)
// ----------------------------------------------------------------------------
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so the memory maps onto RAM
    // primitives; the top masks rdata until a read has actually completed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cache_probe_tracer.sv
// ----------------------------------------------------------------------------
// cache_probe_tracer
// Debug tracer beside the cache controller. Logs every controller FSM state
// change into a circular trace RAM (WRAP / STOP_FULL / TRIGGER modes) and
// keeps saturating hit / miss / evict counters plus sticky error flags.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   enable, clear, mode       capture control; clear is synchronous
//   trig_addr, post_count     trigger address and post-trigger entry count
//   fsm_state, way_hit,
//   req_addr, evict           snooped controller signals
//   rd_en, rd_idx             trace read request (1-cycle latency)
//   rd_data, rd_valid         trace read result {ts, state, way_idx, hit, addr}
//   wr_ptr, entry_count       next write index, number of valid entries
//   tr_state                  tracer state (IDLE/RUN/POST/DONE)
//   triggered, multi_hit_err  sticky flags
//   hit_cnt, miss_cnt,
//   evict_cnt                 saturating event counters
// ----------------------------------------------------------------------------
module cache_probe_tracer
    import cache_probe_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int ADDR_W   = 32,
    parameter int STATE_W  = 4,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 16,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [1:0]                mode,
    input  logic [ADDR_W-1:0]         trig_addr,
    input  logic [$clog2(DEPTH)-1:0]  post_count,
    input  logic [STATE_W-1:0]        fsm_state,
    input  logic [NUM_WAYS-1:0]       way_hit,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      evict,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_idx,
    output logic [entry_width(TS_W, STATE_W, $clog2(NUM_WAYS), ADDR_W)-1:0] rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH)-1:0]  wr_ptr,
    output logic [$clog2(DEPTH):0]    entry_count,
    output logic [1:0]                tr_state,
    output logic                      triggered,
    output logic                      multi_hit_err,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt,
    output logic [CNT_W-1:0]          evict_cnt
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int WAY_W   = $clog2(NUM_WAYS);
    localparam int ENTRY_W = entry_width(TS_W, STATE_W, WAY_W, ADDR_W);

    localparam logic [IDX_W:0]     FULL_COUNT  = (IDX_W+1)'(DEPTH);
    localparam logic [STATE_W-1:0] S_IDLE      = STATE_W'(CS_IDLE);
    localparam logic [STATE_W-1:0] S_RD_HIT    = STATE_W'(CS_RD_HIT);
    localparam logic [STATE_W-1:0] S_WR_HIT    = STATE_W'(CS_WR_HIT);
    localparam logic [STATE_W-1:0] S_RD_ALLOC  = STATE_W'(CS_RD_ALLOC);
    localparam logic [STATE_W-1:0] S_WR_ALLOC  = STATE_W'(CS_WR_ALLOC);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tr_state_e           tr_reg, tr_next;
    logic [1:0]          mode_reg, mode_next;
    logic [IDX_W-1:0]    remain_reg, remain_next;
    logic [IDX_W-1:0]    wr_ptr_reg;
    logic [IDX_W:0]      count_reg;
    logic [STATE_W-1:0]  prev_state_reg;
    logic [TS_W-1:0]     ts_reg;
    logic                triggered_reg;
    logic                multi_hit_reg;
    logic                rd_valid_reg;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic               state_change;
    logic               capture;
    logic               trig_set;
    logic               multi_hit;
    logic [IDX_W:0]     count_inc;
    logic [WAY_W-1:0]   way_idx;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] ram_q;

    assign state_change = (fsm_state != prev_state_reg);

    // clear wins over capture, so a clear cycle never writes the RAM.
    assign capture = state_change && enable && !clear &&
                     ((tr_reg == TR_RUN) || (tr_reg == TR_POST));

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_hit = ((way_hit & (way_hit - NUM_WAYS'(1))) != '0);

    assign count_inc = (count_reg == FULL_COUNT) ? count_reg : count_reg + 1'b1;

    // Lowest set bit wins: scan high to low so the last match is the lowest.
    always_comb begin
        way_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                way_idx = WAY_W'(i);
            end
        end
    end

    assign entry = {ts_reg, fsm_state, way_idx, |way_hit, req_addr};

    // ------------------------------------------------------------------
    // Tracer FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        tr_next     = tr_reg;
        mode_next   = mode_reg;
        remain_next = remain_reg;
        trig_set    = 1'b0;
        if (clear) begin
            tr_next = TR_IDLE;
        end else begin
            case (tr_reg)
                TR_IDLE: begin
                    if (enable) begin
                        tr_next   = TR_RUN;
                        mode_next = mode;
                    end
                end
                TR_RUN: begin
                    if (!enable) begin
                        tr_next = TR_IDLE;
                    end else if (capture) begin
                        // WRAP and the reserved code just keep writing.
                        if (mode_reg == MODE_STOP_FULL) begin
                            if (count_inc == FULL_COUNT) begin
                                tr_next = TR_DONE;
                            end
                        end else if (mode_reg == MODE_TRIGGER && req_addr == trig_addr) begin
                            trig_set = 1'b1;
                            if (post_count == '0) begin
                                tr_next = TR_DONE;
                            end else begin
                                tr_next     = TR_POST;
                                remain_next = post_count;
                            end
                        end
                    end
                end
                TR_POST: begin
                    if (!enable) begin
                        tr_next = TR_IDLE;
                    end else if (capture) begin
                        remain_next = remain_reg - 1'b1;
                        if (remain_reg == IDX_W'(1)) begin
                            tr_next = TR_DONE;
                        end
                    end
                end
                TR_DONE: begin
                    tr_next = TR_DONE;
                end
                default: begin
                    tr_next = TR_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_reg         <= TR_IDLE;
            mode_reg       <= MODE_WRAP;
            remain_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            prev_state_reg <= S_IDLE;
            ts_reg         <= '0;
            triggered_reg  <= 1'b0;
            multi_hit_reg  <= 1'b0;
            rd_valid_reg   <= 1'b0;
        end else begin
            tr_reg         <= tr_next;
            mode_reg       <= mode_next;
            remain_reg     <= remain_next;
            prev_state_reg <= fsm_state;
            ts_reg         <= ts_reg + 1'b1;
            rd_valid_reg   <= rd_en;
            if (clear) begin
                wr_ptr_reg    <= '0;
                count_reg     <= '0;
                triggered_reg <= 1'b0;
                multi_hit_reg <= 1'b0;
            end else begin
                if (capture) begin
                    // Natural power-of-two wrap of the pointer.
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    count_reg  <= count_inc;
                end
                if (trig_set) begin
                    triggered_reg <= 1'b1;
                end
                if (multi_hit) begin
                    multi_hit_reg <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters (run whenever enable=1, any tracer state)
    // ------------------------------------------------------------------
    logic [NUM_CNT-1:0]            cnt_event;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_all;

    assign cnt_event[CNT_HIT]   = enable && state_change &&
                                  (fsm_state == S_RD_HIT || fsm_state == S_WR_HIT);
    assign cnt_event[CNT_MISS]  = enable && state_change &&
                                  (fsm_state == S_RD_ALLOC || fsm_state == S_WR_ALLOC);
    assign cnt_event[CNT_EVICT] = enable && evict;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (clear) begin
                    cnt_reg <= '0;
                end else if (cnt_event[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Trace memory
    // ------------------------------------------------------------------
    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trace_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr_reg),
        .wdata (entry),
        .re    (rd_en),
        .raddr (rd_idx),
        .rdata (ram_q)
    );

    // The RAM read register has no reset; masking with rd_valid keeps
    // rd_data at zero out of reset and between reads.
    assign rd_data       = rd_valid_reg ? ram_q : '0;
    assign rd_valid      = rd_valid_reg;
    assign wr_ptr        = wr_ptr_reg;
    assign entry_count   = count_reg;
    assign tr_state      = tr_reg;
    assign triggered     = triggered_reg;
    assign multi_hit_err = multi_hit_reg;
    assign hit_cnt       = cnt_all[CNT_HIT];
    assign miss_cnt      = cnt_all[CNT_MISS];
    assign evict_cnt     = cnt_all[CNT_EVICT];

endmodule

// File: tb/tb_cache_probe_tracer.sv
// ----------------------------------------------------------------------------
// tb_cache_probe_tracer
// Directed bench for cache_probe_tracer (default parameters) plus a CNT_W=4
// instance sharing the same stimulus for counter saturation.
// ----------------------------------------------------------------------------
module tb_cache_probe_tracer;

    localparam int EW = 55;  // 16 + 4 + 2 + 1 + 32

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] trig_addr = 32'd0;
    logic [3:0]  post_count = 4'd0;
    logic [3:0]  fsm_state = 4'd0;
    logic [3:0]  way_hit = 4'd0;
    logic [31:0] req_addr = 32'd0;
    logic        evict = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_idx = 4'd0;

    logic [EW-1:0] rd_data;
    logic          rd_valid;
    logic [3:0]    wr_ptr;
    logic [4:0]    entry_count;
    logic [1:0]    tr_state;
    logic          triggered;
    logic          multi_hit_err;
    logic [31:0]   hit_cnt, miss_cnt, evict_cnt;

    logic [EW-1:0] s_rd_data;
    logic          s_rd_valid;
    logic [3:0]    s_wr_ptr;
    logic [4:0]    s_entry_count;
    logic [1:0]    s_tr_state;
    logic          s_triggered;
    logic          s_multi_hit_err;
    logic [3:0]    s_hit_cnt, s_miss_cnt, s_evict_cnt;

    cache_probe_tracer u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .mode(mode),
        .trig_addr(trig_addr), .post_count(post_count), .fsm_state(fsm_state),
        .way_hit(way_hit), .req_addr(req_addr), .evict(evict), .rd_en(rd_en),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid), .wr_ptr(wr_ptr),
        .entry_count(entry_count), .tr_state(tr_state), .triggered(triggered),
        .multi_hit_err(multi_hit_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .evict_cnt(evict_cnt)
    );

    cache_probe_tracer #(.CNT_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .mode(mode),
        .trig_addr(trig_addr), .post_count(post_count), .fsm_state(fsm_state),
        .way_hit(way_hit), .req_addr(req_addr), .evict(evict), .rd_en(rd_en),
        .rd_idx(rd_idx), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .wr_ptr(s_wr_ptr),
        .entry_count(s_entry_count), .tr_state(s_tr_state), .triggered(s_triggered),
        .multi_hit_err(s_multi_hit_err), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt),
        .evict_cnt(s_evict_cnt)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release.
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int          n_vec = 0;
    int          n_miss = 0;
    logic [3:0]  cur_state = 4'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [EW-1:0] mk_ent(input logic [15:0] ts, input logic [3:0] s,
                                             input logic [3:0] wh, input logic [31:0] addr);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) if (wh[i]) idx = 2'(i);
        return {ts, s, idx, |wh, addr};
    endfunction

    // Drive a specific controller state for one edge; ent is the entry that
    // would be written if this edge captures.
    task automatic set_fsm(input logic [3:0] s, input logic [31:0] addr,
                           input logic [3:0] wh, output logic [EW-1:0] ent);
        fsm_state = s;
        req_addr  = addr;
        way_hit   = wh;
        cur_state = s;
        ent = mk_ent(cyc[15:0], s, wh, addr);
        tick();
        way_hit = 4'd0;
    endtask

    task automatic change(input logic [31:0] addr, input logic [3:0] wh, output logic [EW-1:0] ent);
        logic [3:0] s;
        s = (cur_state == 4'd7) ? 4'd1 : cur_state + 4'd1;
        set_fsm(s, addr, wh, ent);
    endtask

    task automatic read_entry(input logic [3:0] idx, output logic [EW-1:0] d, output logic v);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        d = rd_data;
        v = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [EW-1:0] e, e_a, e_b, e_hit, e_t3_3, e_trig, e_new;
    logic [EW-1:0] d;
    logic          v;
    logic [EW-1:0] ents [20];

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- reset state ----------------
        check_eq("rst_tr_state", 64'(tr_state), 64'd0);
        check_eq("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        check_eq("rst_entry_count", 64'(entry_count), 64'd0);
        check_eq("rst_flags", 64'({triggered, multi_hit_err, rd_valid}), 64'd0);
        check_eq("rst_counters", 64'(hit_cnt | miss_cnt | evict_cnt), 64'd0);
        check_eq("rst_rd_data", 64'(rd_data), 64'd0);

        // ---------------- WRAP: 20 changes ----------------
        mode = 2'd0;
        enable = 1'b1;
        tick();
        check_eq("wrap_run", 64'(tr_state), 64'd1);
        for (int k = 0; k < 20; k++) begin
            change(32'h1000 + 32'(k), 4'd0, ents[k]);
        end
        check_eq("wrap_count", 64'(entry_count), 64'd16);
        check_eq("wrap_wr_ptr", 64'(wr_ptr), 64'd4);
        read_entry(4'd3, d, v);
        check_eq("wrap_idx3", 64'(d), 64'(ents[19]));
        check_eq("wrap_rd_valid", 64'(v), 64'd1);
        tick();
        check_eq("rd_valid_pulse", 64'(rd_valid), 64'd0);
        read_entry(4'd4, d, v);
        check_eq("wrap_idx4_oldest", 64'(d), 64'(ents[4]));
        check_eq("wrap_hit_cnt", 64'(hit_cnt), 64'd6);
        check_eq("wrap_miss_cnt", 64'(miss_cnt), 64'd6);

        // ---------------- STOP_FULL ----------------
        mode = 2'd1;
        pulse_clear();
        check_eq("clr_count", 64'(entry_count), 64'd0);
        check_eq("clr_tr_state", 64'(tr_state), 64'd0);
        check_eq("clr_hit_cnt", 64'(hit_cnt), 64'd0);
        tick();
        for (int k = 0; k < 16; k++) begin
            change(32'h2000 + 32'(k), 4'd0, e);
            if (k == 0) e_a = e;
        end
        check_eq("full_done", 64'(tr_state), 64'd3);
        check_eq("full_count", 64'(entry_count), 64'd16);
        change(32'h2FFF, 4'd0, e);
        check_eq("full_17_wr_ptr", 64'(wr_ptr), 64'd0);
        check_eq("full_17_count", 64'(entry_count), 64'd16);
        read_entry(4'd0, d, v);
        check_eq("full_idx0_kept", 64'(d), 64'(e_a));

        // ---------------- TRIGGER, post_count=3 ----------------
        mode = 2'd2;
        trig_addr = 32'h40;
        post_count = 4'd3;
        pulse_clear();
        tick();
        change(32'h10, 4'd0, e);
        change(32'h20, 4'd0, e);
        check_eq("trig_not_yet", 64'(triggered), 64'd0);
        change(32'h40, 4'b1000, e_trig);
        check_eq("trig_flag", 64'(triggered), 64'd1);
        check_eq("trig_post", 64'(tr_state), 64'd2);
        change(32'h50, 4'd0, e_t3_3);
        change(32'h60, 4'd0, e);
        check_eq("trig_still_post", 64'(tr_state), 64'd2);
        change(32'h70, 4'd0, e);
        check_eq("trig_done", 64'(tr_state), 64'd3);
        check_eq("trig_wr_ptr", 64'(wr_ptr), 64'd6);
        change(32'h80, 4'd0, e);
        check_eq("trig_done_no_write", 64'(wr_ptr), 64'd6);
        read_entry(4'd2, d, v);
        check_eq("trig_entry", 64'(d), 64'(e_trig));

        // ---------------- TRIGGER, post_count=0 ----------------
        post_count = 4'd0;
        pulse_clear();
        check_eq("clr_triggered", 64'(triggered), 64'd0);
        tick();
        change(32'h40, 4'd0, e);
        check_eq("trig0_done", 64'(tr_state), 64'd3);
        check_eq("trig0_wr_ptr", 64'(wr_ptr), 64'd1);
        check_eq("trig0_flag", 64'(triggered), 64'd1);

        // ---------------- counters ----------------
        set_fsm(4'd0, 32'h0, 4'd0, e);
        mode = 2'd0;
        pulse_clear();
        tick();
        set_fsm(4'd2, 32'h300, 4'b0100, e_hit);  // RD_HIT
        set_fsm(4'd0, 32'h304, 4'd0, e);         // IDLE
        set_fsm(4'd5, 32'h308, 4'd0, e);         // WR_ALLOC
        for (int k = 0; k < 2; k++) begin
            evict = 1'b1; tick();
            evict = 1'b0; tick();
        end
        check_eq("cnt_hit", 64'(hit_cnt), 64'd1);
        check_eq("cnt_miss", 64'(miss_cnt), 64'd1);
        check_eq("cnt_evict", 64'(evict_cnt), 64'd2);
        for (int k = 0; k < 17; k++) begin
            evict = 1'b1; tick();
            evict = 1'b0; tick();
        end
        check_eq("cnt_evict_19", 64'(evict_cnt), 64'd19);
        check_eq("sat_evict_15", 64'(s_evict_cnt), 64'd15);
        check_eq("sat_hit_1", 64'(s_hit_cnt), 64'd1);
        read_entry(4'd0, d, v);
        check_eq("cnt_idx0_hit_entry", 64'(d), 64'(e_hit));
        check_eq("cnt_wr_ptr", 64'(wr_ptr), 64'd3);

        // ---------------- multi-hit and clear+capture ----------------
        way_hit = 4'b0110;
        tick();
        way_hit = 4'd0;
        check_eq("multi_hit_set", 64'(multi_hit_err), 64'd1);
        tick();
        check_eq("multi_hit_sticky", 64'(multi_hit_err), 64'd1);
        clear = 1'b1;
        change(32'h500, 4'd0, e);
        clear = 1'b0;
        check_eq("clrcap_wr_ptr", 64'(wr_ptr), 64'd0);
        check_eq("clrcap_count", 64'(entry_count), 64'd0);
        check_eq("clrcap_multi_hit", 64'(multi_hit_err), 64'd0);
        check_eq("clrcap_evict", 64'(evict_cnt), 64'd0);
        read_entry(4'd3, d, v);
        check_eq("clrcap_no_write", 64'(d), 64'(e_t3_3));

        // ---------------- read-before-write ----------------
        rd_en = 1'b1;
        rd_idx = 4'd0;
        change(32'h600, 4'd0, e_new);
        rd_en = 1'b0;
        check_eq("rbw_old_data", 64'(rd_data), 64'(e_hit));
        read_entry(4'd0, d, v);
        check_eq("rbw_new_data", 64'(d), 64'(e_new));

        // ---------------- async reset mid-POST ----------------
        mode = 2'd2;
        trig_addr = 32'h40;
        post_count = 4'd3;
        pulse_clear();
        tick();
        rd_en = 1'b1;
        rd_idx = 4'd5;
        change(32'h40, 4'd0, e);
        rd_en = 1'b0;
        check_eq("post_before_rst", 64'(tr_state), 64'd2);
        check_eq("rd_valid_before_rst", 64'(rd_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_tr_state", 64'(tr_state), 64'd0);
        check_eq("arst_wr_ptr", 64'(wr_ptr), 64'd0);
        check_eq("arst_count", 64'(entry_count), 64'd0);
        check_eq("arst_flags", 64'({triggered, multi_hit_err, rd_valid}), 64'd0);
        check_eq("arst_rd_data", 64'(rd_data), 64'd0);
        check_eq("arst_counters", 64'(hit_cnt | miss_cnt | evict_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
